// File: rtl/rti_pkg.sv
// Shared types and widths for the real-time input core.
// A buffer word is {timestamp, data}, the same layout the output cores use.
package rti_pkg;

    localparam int TS_W   = 64;
    localparam int DATA_W = 64;
    localparam int WORD_W = TS_W + DATA_W;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] data;
    } rti_word_t;

endpackage

// File: rtl/rti_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head word.
// Ports:
//   clk    system clock
//   srst   synchronous clear of pointers, occupancy and flags
//   din    word to push          wr_en  push (caller guarantees room)
//   rd_en  pop head (ignored when empty)
//   dout   head word, valid while empty=0
//   full   occupancy >= FULL_THRESHOLD (registered)
//   empty  occupancy == 0 (registered)
module rti_sync_fifo
    import rti_pkg::*;
#(
    parameter int DEPTH          = 8192,
    parameter int FULL_THRESHOLD = 8100
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [WORD_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              full_q, empty_q;
    logic              pop;

    always_comb begin
        pop      = rd_en & ~empty_q;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(pop);
        // The head after this edge is either the word being written right now
        // (FIFO empty, or last word leaving) or already sitting in memory.
        // When nothing will be left, keep the old word rather than read stale RAM.
        dout_d = dout_q;
        if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = din;
        end else if (count_d != '0) begin
            dout_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            full_q   <= (count_d >= CW'(FULL_THRESHOLD));
            empty_q  <= (count_d == '0);
        end
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/rti_core.sv
// Real-time input core: timestamps input events with the shared counter and
// queues {timestamp, data} words for CPU readout.
// Ports:
//   clk, reset (sync, active-high), flush (sync FIFO clear, keeps error info)
//   auto_start  capture enable        counter     global timestamp
//   event_data  input sample          event_valid capture strobe
//   read        pop head word         rti_out     head word (FWFT)
//   captured / overflow_error / underflow_error   1-cycle pulses
//   overflow_error_data  last dropped word  overflow_count  saturating drop count
//   full / empty         registered occupancy flags
module rti_core
    import rti_pkg::*;
#(
    parameter int DEPTH          = 8192,
    parameter int FULL_THRESHOLD = 8100,
    parameter int CHANGE_MODE    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              auto_start,
    input  logic [TS_W-1:0]   counter,
    input  logic [DATA_W-1:0] event_data,
    input  logic              event_valid,
    input  logic              read,
    output logic [WORD_W-1:0] rti_out,
    output logic              captured,
    output logic              overflow_error,
    output logic [WORD_W-1:0] overflow_error_data,
    output logic [31:0]       overflow_count,
    output logic              underflow_error,
    output logic              full,
    output logic              empty
);

    logic              srst;
    logic              trigger;
    logic              push, drop;
    logic              fifo_full, fifo_empty;

    logic [DATA_W-1:0] last_data_q;
    rti_word_t         cap_word_q, cap_word_d;
    logic              cap_vld_q;
    logic [WORD_W-1:0] ovf_data_q, ovf_data_d;
    logic [31:0]       ovf_cnt_q, ovf_cnt_d;

    assign srst = reset | flush;

    always_comb begin
        trigger = auto_start & ~srst &
                  (event_valid | ((CHANGE_MODE != 0) && (event_data != last_data_q)));
        // The full flag is the pre-edge registered value, so a word decided
        // here always has slack left in the RAM.
        push = cap_vld_q & ~fifo_full & ~srst;
        drop = cap_vld_q &  fifo_full & ~srst;

        cap_word_d      = cap_word_q;
        cap_word_d.ts   = trigger ? counter    : cap_word_q.ts;
        cap_word_d.data = trigger ? event_data : cap_word_q.data;

        ovf_data_d = drop ? cap_word_q : ovf_data_q;
        ovf_cnt_d  = (drop && (ovf_cnt_q != 32'hFFFF_FFFF)) ? ovf_cnt_q + 32'd1 : ovf_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_data_q <= '0;
            ovf_data_q  <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            last_data_q <= event_data;
            ovf_data_q  <= ovf_data_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cap_word_q <= '0;
            cap_vld_q  <= 1'b0;
        end else begin
            cap_word_q <= cap_word_d;
            cap_vld_q  <= trigger;
        end
    end

    rti_sync_fifo #(
        .DEPTH          (DEPTH),
        .FULL_THRESHOLD (FULL_THRESHOLD)
    ) u_fifo (
        .clk   (clk),
        .srst  (srst),
        .din   (cap_word_q),
        .wr_en (push),
        .rd_en (read & ~srst),
        .dout  (rti_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign captured            = push;
    assign overflow_error      = drop;
    assign overflow_error_data = ovf_data_q;
    assign overflow_count      = ovf_cnt_q;
    assign underflow_error     = read & fifo_empty & ~srst;
    assign full                = fifo_full;
    assign empty               = fifo_empty;

endmodule

// File: tb/tb_rti_core.sv
module tb_rti_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, flush, auto_start, event_valid, read;
    logic [63:0]  counter, event_data;
    logic [127:0] rti_out, ovf_data;
    logic         captured, overflow_error, underflow_error, full, empty;
    logic [31:0]  ovf_count;

    logic         flush2, auto_start2, event_valid2, read2;
    logic [63:0]  event_data2;
    logic [127:0] rti_out2, ovf_data2;
    logic         captured2, overflow_error2, underflow_error2, full2, empty2;
    logic [31:0]  ovf_count2;

    rti_core dut (
        .clk(clk), .reset(reset), .flush(flush), .auto_start(auto_start),
        .counter(counter), .event_data(event_data), .event_valid(event_valid),
        .read(read), .rti_out(rti_out), .captured(captured),
        .overflow_error(overflow_error), .overflow_error_data(ovf_data),
        .overflow_count(ovf_count), .underflow_error(underflow_error),
        .full(full), .empty(empty)
    );

    rti_core #(.DEPTH(16), .FULL_THRESHOLD(12), .CHANGE_MODE(1)) dut_chg (
        .clk(clk), .reset(reset), .flush(flush2), .auto_start(auto_start2),
        .counter(counter), .event_data(event_data2), .event_valid(event_valid2),
        .read(read2), .rti_out(rti_out2), .captured(captured2),
        .overflow_error(overflow_error2), .overflow_error_data(ovf_data2),
        .overflow_count(ovf_count2), .underflow_error(underflow_error2),
        .full(full2), .empty(empty2)
    );

    int checks = 0;
    int errors = 0;
    logic [127:0] sb[$];

    typedef struct {
        logic        as;
        logic        vld;
        logic [63:0] d;
        logic        exp_cap;
    } vec_t;
    vec_t vecs[8];

    int n, nexp, capc, ovfc;
    logic [127:0] exp_ovf;

    task automatic step();
        @(posedge clk);
        #1;
        counter = counter + 64'd1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Pops the main DUT until empty, comparing every head against the scoreboard.
    task automatic drain(output int cnt);
        logic [127:0] e;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            read = 1'b0;
            #2;
            if (empty) break;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_extra_word actual=%h required=none", rti_out);
            end else begin
                e = sb.pop_front();
                chkw("drain_data", rti_out, e);
            end
            read = 1'b1;
            cnt++;
        end
        read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; auto_start = 1'b0; event_valid = 1'b0; read = 1'b0;
        counter = '0; event_data = '0;
        flush2 = 1'b0; auto_start2 = 1'b0; event_valid2 = 1'b0; read2 = 1'b0; event_data2 = '0;

        vecs[0] = '{1'b1, 1'b1, 64'h11, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 64'h22, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 64'h33, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 64'h44, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 64'h55, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 64'h66, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 64'h77, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

        // reset state
        step(); step(); #2;
        chk1("rst_empty", empty, 1'b1);
        chkw("rst_rti_out", rti_out, '0);
        chk1("rst_full", full, 1'b0);
        chk1("rst_captured", captured, 1'b0);
        chk1("rst_overflow", overflow_error, 1'b0);
        chk1("rst_underflow", underflow_error, 1'b0);
        chkw("rst_ovf_data", ovf_data, '0);
        chk32("rst_ovf_count", ovf_count, 0);
        chk1("rst_empty_chg", empty2, 1'b1);
        step(); reset = 1'b0;

        // T1 capture on strobe
        step(); counter = 64'd100; auto_start = 1'b1; event_valid = 1'b1; event_data = 64'hA5;
        sb.push_back({64'd100, 64'hA5});
        #2; chk1("t1_no_early_capture", captured, 1'b0);
        step(); event_valid = 1'b0;
        #2; chk1("t1_captured", captured, 1'b1); chk1("t1_empty_n1", empty, 1'b1);
        step();
        #2; chk1("t1_empty_n2", empty, 1'b0); chkw("t1_rti_out", rti_out, sb.pop_front());
        read = 1'b1;
        step(); read = 1'b0;
        #2; chk1("t1_empty_after_read", empty, 1'b1);

        // vector table, one vector per cycle
        nexp = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            auto_start = vecs[i].as; event_valid = vecs[i].vld; event_data = vecs[i].d;
            if (vecs[i].exp_cap) begin
                sb.push_back({counter, event_data});
                nexp++;
            end
            #2;
            if (i > 0) chk1("vec_captured", captured, vecs[i-1].exp_cap);
        end
        step(); event_valid = 1'b0; auto_start = 1'b1;
        #2; chk1("vec_captured_last", captured, vecs[7].exp_cap);
        drain(n);
        chk32("vec_word_count", n, nexp);
        chk32("vec_sb_empty", sb.size(), 0);

        // T2 change mode on the second instance
        auto_start2 = 1'b1; event_data2 = '0; capc = 0;
        for (int i = 0; i < 3; i++) begin
            step(); #2; if (captured2) capc++;
        end
        step(); counter = 64'd50; event_data2 = 64'd3;
        #2; if (captured2) capc++;
        for (int i = 0; i < 5; i++) begin
            step(); #2; if (captured2) capc++;
        end
        chk32("t2_one_capture", capc, 1);
        chk1("t2_nonempty", empty2, 1'b0);
        chkw("t2_word", rti_out2, {64'd50, 64'd3});
        read2 = 1'b1;
        step(); read2 = 1'b0;
        #2; chk1("t2_empty_after_read", empty2, 1'b1);
        auto_start2 = 1'b0; capc = 0;
        for (int i = 0; i < 6; i++) begin
            step(); event_data2 = 64'(i * 7 + 1);
            #2; if (captured2) capc++;
        end
        chk32("t2_disabled_no_capture", capc, 0);
        chk1("t2_disabled_empty", empty2, 1'b1);

        // T4 simultaneous push and pop at occupancy 5
        for (int i = 0; i < 5; i++) begin
            step(); event_valid = 1'b1; event_data = 64'h400 + 64'(i);
            sb.push_back({counter, event_data});
        end
        step(); event_valid = 1'b0;
        step(); event_valid = 1'b1; event_data = 64'hC0;
        sb.push_back({counter, event_data});
        #2; chk1("t4_occ5_nonempty", empty, 1'b0);
        step(); event_valid = 1'b0;
        #2; chk1("t4_capture_with_read", captured, 1'b1);
        chkw("t4_head", rti_out, sb.pop_front());
        read = 1'b1;
        drain(n);
        chk32("t4_occupancy_kept", n, 5);
        chk32("t4_sb_empty", sb.size(), 0);

        // read on empty
        step(); read = 1'b1;
        #2; chk1("t4_underflow", underflow_error, 1'b1);
        step(); read = 1'b0;
        #2; chk1("t4_underflow_clear", underflow_error, 1'b0); chk1("t4_still_empty", empty, 1'b1);
        step(); event_valid = 1'b1; event_data = 64'hE1;
        sb.push_back({counter, event_data});
        step(); event_valid = 1'b0;
        drain(n);
        chk32("t4_after_underflow_words", n, 1);

        // T3 overflow
        capc = 0; ovfc = 0; exp_ovf = '0;
        for (int k = 1; k <= 8102; k++) begin
            step(); event_valid = 1'b1; event_data = 64'(k);
            if (k <= 8100) sb.push_back({counter, event_data});
            else if (k == 8102) exp_ovf = {counter, event_data};
            #2;
            if (captured) capc++;
            if (overflow_error) ovfc++;
            if (k == 8101) chk1("t3_full_below_threshold", full, 1'b0);
            if (k == 8102) chk1("t3_full_at_threshold", full, 1'b1);
        end
        step(); event_valid = 1'b0;
        #2; if (captured) capc++; if (overflow_error) ovfc++;
        step();
        #2; if (captured) capc++; if (overflow_error) ovfc++;
        chk32("t3_captures", capc, 8100);
        chk32("t3_overflow_pulses", ovfc, 2);
        chk32("t3_overflow_count", ovf_count, 2);
        chkw("t3_overflow_data", ovf_data, exp_ovf);
        chk1("t3_full", full, 1'b1);
        step(); event_valid = 1'b1; event_data = 64'hDEAD;
        step(); event_valid = 1'b0;
        #2; chk1("t3_extra_overflow", overflow_error, 1'b1);
        step();
        #2; chk32("t3_overflow_count3", ovf_count, 3);
        for (int i = 0; i < 3; i++) begin
            step(); read = 1'b0;
            #2; chkw("t3_head", rti_out, sb.pop_front());
            read = 1'b1;
        end
        step(); read = 1'b0;
        #2; chk1("t3_full_released", full, 1'b0);

        // T5 flush
        step(); flush = 1'b1;
        step(); flush = 1'b0;
        #2; chk1("t5_flush_empty", empty, 1'b1); chk32("t5_flush_keeps_count", ovf_count, 3);
        sb.delete();
        for (int i = 0; i < 10; i++) begin
            step(); event_valid = 1'b1; event_data = 64'h500 + 64'(i);
        end
        step(); event_valid = 1'b0;
        step();
        #2; chk1("t5_ten_queued", empty, 1'b0);
        step(); event_valid = 1'b1; event_data = 64'hBAD;
        step(); flush = 1'b1; read = 1'b1; event_data = 64'hBAD2;
        #2; chk1("t5_inflight_no_capture", captured, 1'b0);
        chk1("t5_flush_no_underflow", underflow_error, 1'b0);
        step(); flush = 1'b0; read = 1'b0; event_valid = 1'b0;
        #2; chk1("t5_empty_after_flush", empty, 1'b1);
        chk1("t5_flush_trigger_discarded", captured, 1'b0);
        chk32("t5_count_retained", ovf_count, 3);
        step();
        #2; chk1("t5_still_empty", empty, 1'b1);
        step(); event_valid = 1'b1; event_data = 64'h77;
        sb.push_back({counter, event_data});
        step(); event_valid = 1'b0;
        drain(n);
        chk32("t5_post_flush_words", n, 1);

        // T6 reset while full with overflow_count=3
        for (int k = 0; k < 8100; k++) begin
            step(); event_valid = 1'b1; event_data = 64'(k);
        end
        step(); event_valid = 1'b0;
        step();
        #2; chk1("t6_full_before_reset", full, 1'b1); chk32("t6_count_before_reset", ovf_count, 3);
        step(); reset = 1'b1; event_valid = 1'b1;
        step(); reset = 1'b0; event_valid = 1'b0;
        #2;
        chk1("t6_empty", empty, 1'b1);
        chkw("t6_rti_out", rti_out, '0);
        chk1("t6_full", full, 1'b0);
        chk1("t6_captured", captured, 1'b0);
        chk1("t6_overflow", overflow_error, 1'b0);
        chk1("t6_underflow", underflow_error, 1'b0);
        chkw("t6_ovf_data", ovf_data, '0);
        chk32("t6_ovf_count", ovf_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
